// File: rtl/mips_pkg.sv
// Shared opcodes, LSU state encoding and address-check helpers
// for the MIPS load/store unit.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        WB,
        ERR
    } lsu_state_t;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_valid(input logic [5:0] op);
        return (op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU,
                           OP_LHU, OP_LWR, OP_SB, OP_SH, OP_SW});
    endfunction

    function automatic logic misaligned(input logic [5:0] op,
                                        input logic [1:0] ea_lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return ea_lo[0];
            OP_LW, OP_SW:         return ea_lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Places loaded memory bytes onto register lanes and selects
// which register bytes the load writes.
module load_align
    import mips_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [1:0]  i_ea_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data,
    output logic [3:0]  o_be
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_lsh;
    logic [4:0]  w_rsh;

    assign w_byte = i_rdata[{i_ea_lo, 3'b000} +: 8];
    assign w_half = i_ea_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    // LWL shifts left by 3-k bytes; 3-k == ~k for a 2-bit k
    assign w_lsh  = {~i_ea_lo, 3'b000};
    assign w_rsh  = {i_ea_lo, 3'b000};

    always_comb begin
        o_data = '0;
        o_be   = 4'b1111;
        case (i_opcode)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'h0, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'h0, w_half};
            OP_LW:   o_data = i_rdata;
            OP_LWL: begin
                o_data = i_rdata << w_lsh;
                o_be   = 4'b1111 << (~i_ea_lo);
            end
            OP_LWR: begin
                o_data = i_rdata >> w_rsh;
                o_be   = 4'b1111 >> i_ea_lo;
            end
            default: o_be = 4'b0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MIPS load/store unit: one Avalon-style bus transaction per
// instruction, with watchdog abort and regfile load writeback.
module load_store_unit
    import mips_pkg::*;
#(
    parameter int MAX_WAIT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] base,
    input  logic [15:0] offset,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        write_enable_ld,
    output logic [31:0] write_data_ld,
    output logic [3:0]  byteenable_ld
);

    localparam int WDW = $clog2(MAX_WAIT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(MAX_WAIT - 1);

    lsu_state_t     r_state;
    lsu_state_t     w_next;
    logic [31:0]    r_ea;
    logic [5:0]     r_op;
    logic [3:0]     r_be;
    logic [31:0]    r_wdata;
    logic [31:0]    r_rdata;
    logic [WDW-1:0] r_wd;

    logic [31:0]    w_ea;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;
    logic           w_store;
    logic           w_abort;
    logic [31:0]    w_ld_data;
    logic [3:0]     w_ld_be;

    assign w_ea    = base + {{16{offset[15]}}, offset};
    assign w_store = is_store(r_op);
    assign w_abort = (r_state == BUS) && waitrequest && (r_wd == WD_LAST);

    // Store lanes are resolved at issue so the bus sees registered values
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = '0;
        case (opcode)
            OP_SB: begin
                w_be    = 4'b0001 << w_ea[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            OP_SH: begin
                w_be    = w_ea[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data[15:0]}};
            end
            OP_SW:   w_wdata = store_data;
            default: ;
        endcase
    end

    always_comb begin
        w_next          = r_state;
        busy            = 1'b0;
        done            = 1'b0;
        error           = 1'b0;
        read            = 1'b0;
        write           = 1'b0;
        address         = '0;
        byteenable      = '0;
        writedata       = '0;
        write_enable_ld = 1'b0;
        write_data_ld   = '0;
        byteenable_ld   = '0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (!op_valid(opcode) || misaligned(opcode, w_ea[1:0]))
                        w_next = ERR;
                    else
                        w_next = BUS;
                end
            end
            BUS: begin
                busy       = 1'b1;
                read       = !w_store;
                write      = w_store;
                address    = {r_ea[31:2], 2'b00};
                byteenable = r_be;
                writedata  = r_wdata;
                if (w_abort) begin
                    w_next = ERR;
                end else if (!waitrequest) begin
                    if (w_store) begin
                        done   = 1'b1;
                        w_next = IDLE;
                    end else begin
                        w_next = WB;
                    end
                end
            end
            WB: begin
                busy            = 1'b1;
                done            = 1'b1;
                write_enable_ld = 1'b1;
                write_data_ld   = w_ld_data;
                byteenable_ld   = w_ld_be;
                w_next          = IDLE;
            end
            ERR: begin
                busy   = 1'b1;
                done   = 1'b1;
                error  = 1'b1;
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ea    <= '0;
            r_op    <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_ea    <= w_ea;
                r_op    <= opcode;
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_wd    <= '0;
            end
            if (r_state == BUS && waitrequest && !w_abort)
                r_wd <= r_wd + 1'b1;
            if (r_state == BUS && !waitrequest && !w_store)
                r_rdata <= readdata;
        end
    end

    load_align u_align (
        .i_opcode (r_op),
        .i_ea_lo  (r_ea[1:0]),
        .i_rdata  (r_rdata),
        .o_data   (w_ld_data),
        .o_be     (w_ld_be)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level
// reference model of MIPS load/store semantics.
module tb_load_store_unit;
    import mips_pkg::*;

    localparam int MW = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] base;
    logic [15:0] offset;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        write_enable_ld;
    logic [31:0] write_data_ld;
    logic [3:0]  byteenable_ld;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MAX_WAIT(MW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .opcode          (opcode),
        .base            (base),
        .offset          (offset),
        .store_data      (store_data),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .address         (address),
        .read            (read),
        .write           (write),
        .byteenable      (byteenable),
        .writedata       (writedata),
        .readdata        (readdata),
        .waitrequest     (waitrequest),
        .write_enable_ld (write_enable_ld),
        .write_data_ld   (write_data_ld),
        .byteenable_ld   (byteenable_ld)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Register bytes written by a load, from the mem word and ea[1:0]
    task automatic model_load(input logic [5:0] op, input int k,
                              input logic [31:0] rd,
                              output logic [31:0] d, output logic [3:0] be);
        logic [7:0] m[4];
        logic [7:0] r[4];
        for (int i = 0; i < 4; i++) begin
            m[i] = rd[8*i +: 8];
            r[i] = 8'h00;
        end
        be = 4'b1111;
        case (op)
            OP_LB:  for (int i = 0; i < 4; i++) r[i] = (i == 0) ? m[k] : {8{m[k][7]}};
            OP_LBU: r[0] = m[k];
            OP_LH, OP_LHU: begin
                r[0] = m[k];
                r[1] = m[k+1];
                r[2] = (op == OP_LH) ? {8{m[k+1][7]}} : 8'h00;
                r[3] = r[2];
            end
            OP_LW:  for (int i = 0; i < 4; i++) r[i] = m[i];
            OP_LWL: begin
                be = 4'b0000;
                for (int j = 0; j <= k; j++) begin
                    r[3-k+j]  = m[j];
                    be[3-k+j] = 1'b1;
                end
            end
            OP_LWR: begin
                be = 4'b0000;
                for (int j = 0; j <= 3 - k; j++) begin
                    r[j]  = m[k+j];
                    be[j] = 1'b1;
                end
            end
            default: be = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) d[8*i +: 8] = r[i];
    endtask

    task automatic model_store(input logic [5:0] op, input int k,
                               input logic [31:0] sd,
                               output logic [3:0] be, output logic [31:0] wd);
        be = 4'b1111;
        wd = 32'h0;
        case (op)
            OP_SB: begin
                be = 4'b0000;
                be[k] = 1'b1;
                for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[7:0];
            end
            OP_SH: begin
                be = (k == 2) ? 4'b1100 : 4'b0011;
                wd = {sd[15:0], sd[15:0]};
            end
            OP_SW: wd = sd;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [5:0] op, input logic [31:0] b,
                          input logic [15:0] off, input logic [31:0] sd,
                          input logic [31:0] rd, input int nwait);
        logic [31:0] ea, exp_wd, exp_ld, mask;
        logic [3:0]  exp_be, exp_bld;
        int          k, exp_lat, exp_req, cyc, stalls, reqs;
        bit          legal, st, ld, mis, abort, exp_err, got_done, got_we;
        ea    = b + {{16{off[15]}}, off};
        k     = int'(ea[1:0]);
        st    = op inside {OP_SB, OP_SH, OP_SW};
        legal = st || (op inside {OP_LB, OP_LH, OP_LWL, OP_LW,
                                  OP_LBU, OP_LHU, OP_LWR});
        ld    = legal && !st;
        mis   = !legal;
        if ((op inside {OP_LH, OP_LHU, OP_SH}) && (k % 2 != 0)) mis = 1;
        if ((op inside {OP_LW, OP_SW}) && k != 0) mis = 1;
        abort   = !mis && nwait >= MW;
        exp_err = mis || abort;
        exp_lat = mis ? 1 : abort ? MW + 1 : ld ? nwait + 2 : nwait + 1;
        exp_req = mis ? 0 : abort ? MW : nwait + 1;
        model_store(op, k, sd, exp_be, exp_wd);
        model_load(op, k, rd, exp_ld, exp_bld);
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{exp_bld[i]}};

        @(negedge clk);
        start = 1; opcode = op; base = b; offset = off;
        store_data = sd; waitrequest = 0;
        @(negedge clk);
        start = 0; base = $urandom; offset = 16'($urandom);
        store_data = $urandom; opcode = 6'($urandom);
        cyc = 1; stalls = 0; reqs = 0; got_done = 0; got_we = 0;
        while (!got_done && cyc <= MW + 20) begin
            waitrequest = (stalls < nwait);
            readdata    = waitrequest ? $urandom : rd;
            #1;
            check("busy", busy, 1);
            check("rd_wr_excl", read && write, 0);
            if (read || write) begin
                reqs++;
                if (waitrequest) stalls++;
                check("req_kind", write, st);
                check("address", address, {ea[31:2], 2'b00});
                check("byteenable", byteenable, exp_be);
                if (write) check("writedata", writedata, exp_wd);
            end
            if (write_enable_ld) begin
                got_we = 1;
                check("ld_data", write_data_ld & mask, exp_ld & mask);
                check("ld_be", byteenable_ld, exp_bld);
            end
            if (done) begin
                got_done = 1;
                check("error", error, exp_err);
                check("latency", cyc, exp_lat);
            end else begin
                check("err_nodone", error, 0);
            end
            @(negedge clk);
            cyc++;
        end
        if (!got_done) check("timeout", 0, 1);
        waitrequest = 0;
        #1;
        check("idle_busy", busy, 0);
        check("req_cycles", reqs, exp_req);
        check("we_seen", got_we, ld && !exp_err);
    endtask

    logic [5:0] ops[12];

    initial begin
        ops = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
                OP_SB, OP_SH, OP_SW, 6'h27, 6'h2F};
        rst = 1; start = 0; opcode = 0; base = 0; offset = 0;
        store_data = 0; readdata = 0; waitrequest = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read", read, 0);
        check("rst_write", write, 0);
        check("rst_addr", address, 0);
        check("rst_we", write_enable_ld, 0);
        repeat (2) @(negedge clk);
        rst = 0;

        run_op(OP_LW,  32'h1000, 16'h0004, 0, 32'hDEADBEEF, 0);
        run_op(OP_LB,  32'h1000, 16'h0003, 0, 32'h80FFFFFF, 0);
        run_op(OP_LBU, 32'h1000, 16'h0003, 0, 32'h80FFFFFF, 0);
        run_op(OP_SH,  32'h2000, 16'h0002, 32'h0000ABCD, 0, 3);
        run_op(OP_LWL, 32'h0010, 16'h0001, 0, 32'h44332211, 0);
        run_op(OP_LWR, 32'h0010, 16'h0003, 0, 32'h44332211, 0);
        run_op(OP_LW,  32'h1000, 16'h0002, 0, 0, 0);
        run_op(OP_SW,  32'h0000, 16'hFFFC, 32'h12345678, 0, 1);
        run_op(6'h2A,  32'h0000, 16'h0000, 0, 0, 0);
        run_op(OP_LW,  32'h1000, 16'h0000, 0, 32'hCAFEF00D, MW - 1);
        run_op(OP_LW,  32'h1000, 16'h0000, 0, 32'hCAFEF00D, MW);
        run_op(OP_SB,  32'h3000, 16'h0001, 32'h000000A5, 0, MW);

        // reset in the middle of a stalled read
        @(negedge clk);
        start = 1; opcode = OP_LW; base = 32'h100; offset = 0;
        waitrequest = 1;
        @(negedge clk);
        start = 0;
        #1;
        check("pre_rst_read", read, 1);
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        check("mid_rst_read", read, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        waitrequest = 0;
        @(negedge clk);
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("post_rst_we", write_enable_ld, 0);
            check("post_rst_busy", busy, 0);
        end
        run_op(OP_LH, 32'h4000, 16'h0002, 0, 32'h8001_7FFF, 0);

        for (int n = 0; n < 200; n++) begin
            run_op(ops[$urandom_range(0, 11)], $urandom,
                   16'($urandom), $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
